// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath blocks: widths, memory FSM states and op codes.
package cpu_pkg;

    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultAddrW = 8;
    // Wide enough for the largest supported access latency (15).
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } op_e;

    function automatic op_e op_from_req(input logic write);
        return write ? OpWr : OpRd;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data memory storage: synchronous write, asynchronous read, whole array cleared on reset.
module dmem_array #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory.sv
// Multi-cycle byte-addressed data memory with a BUSYWAIT stall handshake toward the CPU.
module data_memory
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned ADDR_W  = DefaultAddrW,
    parameter int unsigned LATENCY = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    localparam logic [CntW-1:0] LastCnt = CntW'(LATENCY);

    state_e            state_q;
    op_e               op_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;

    logic              req_valid;
    logic              last_beat;
    logic              mem_we;
    logic [DATA_W-1:0] arr_rdata;

    // READ and WRITE together is an illegal request and is treated as no request.
    assign req_valid = READ ^ WRITE;
    assign last_beat = (state_q == StBusy) && (cnt_q == LastCnt);
    assign mem_we    = last_beat && (op_q == OpWr);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            op_q    <= OpRd;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= ADDRESS;
                        data_q  <= WRITEDATA;
                        op_q    <= op_from_req(WRITE);
                        cnt_q   <= CntW'(1);
                        busy_q  <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (last_beat) begin
                        if (op_q == OpRd) begin
                            rdata_q <= arr_rdata;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    dmem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .we_i   (mem_we),
        .addr_i (addr_q),
        .wdata_i(data_q),
        .rdata_o(arr_rdata)
    );

    // Idle stalls combinationally so the CPU holds in the very cycle it issues the request.
    assign BUSYWAIT = (state_q == StIdle) ? req_valid : busy_q;
    assign READDATA = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected completions, a negedge monitor checks them.
module tb_data_memory;

    localparam int unsigned Lat = 5;

    logic       CLK;
    logic       RESET;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_mem [256];
    logic [7:0] model_rdata;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_prev = 1'b0;
    int         mon_run = 0;

    data_memory #(
        .DATA_W (8),
        .ADDR_W (8),
        .LATENCY(Lat)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a BUSYWAIT high->low transition marks the DONE cycle of an access.
    always @(negedge CLK) begin
        if (RESET) begin
            mon_prev = 1'b0;
            mon_run  = 0;
            sb_q.delete();
        end else begin
            if (BUSYWAIT) begin
                mon_run++;
            end else if (mon_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("busy_len_%s_%0h", e.is_wr ? "wr" : "rd", e.addr),
                          mon_run, Lat + 1);
                    check($sformatf("readdata_%s_%0h", e.is_wr ? "wr" : "rd", e.addr),
                          READDATA, e.rdata);
                end
                mon_run = 0;
            end
            mon_prev = BUSYWAIT;
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        model_rdata = 8'h00;
    endtask

    // Drive a request and record what its completion must look like.
    task automatic issue(input bit is_wr, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        READ      = !is_wr;
        WRITE     = is_wr;
        ADDRESS   = addr;
        WRITEDATA = data;
        if (is_wr) model_mem[addr] = data;
        else model_rdata = model_mem[addr];
        e.is_wr = is_wr;
        e.addr  = addr;
        e.rdata = model_rdata;
        sb_q.push_back(e);
    endtask

    task automatic start(input bit is_wr, input logic [7:0] addr, input logic [7:0] data);
        @(posedge CLK);
        #1;
        issue(is_wr, addr, data);
        #1;
        check("req_cycle_busy", BUSYWAIT, 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * Lat + 10; i++) begin
            @(posedge CLK);
            #1;
            if (!BUSYWAIT) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic access(input bit is_wr, input logic [7:0] addr, input logic [7:0] data);
        start(is_wr, addr, data);
        wait_done();
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        model_clear();
        #12;
        check("reset_busywait", BUSYWAIT, 0);
        check("reset_readdata", READDATA, 0);
        @(negedge CLK);
        #1;
        RESET = 1'b0;

        // Plain read after reset, then write/read round trip.
        access(1'b0, 8'h10, 8'h00);
        access(1'b1, 8'h3C, 8'hA5);
        access(1'b0, 8'h3C, 8'h00);

        // Input changes during BUSY must be ignored.
        start(1'b1, 8'h01, 8'h11);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        ADDRESS   = 8'h02;
        WRITEDATA = 8'hFF;
        wait_done();
        WRITE = 1'b0;
        access(1'b0, 8'h02, 8'h00);
        access(1'b0, 8'h01, 8'h00);

        // Asynchronous reset on BUSY cycle 3 aborts the write.
        start(1'b1, 8'h20, 8'h77);
        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b1;
        WRITE = 1'b0;
        #1;
        check("abort_busywait", BUSYWAIT, 0);
        check("abort_readdata", READDATA, 0);
        model_clear();
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        access(1'b0, 8'h20, 8'h00);

        // Illegal READ and WRITE together: no access, memory untouched.
        access(1'b1, 8'h05, 8'h33);
        @(posedge CLK);
        #1;
        READ      = 1'b1;
        WRITE     = 1'b1;
        ADDRESS   = 8'h05;
        WRITEDATA = 8'hCC;
        #1;
        check("illegal_busywait", BUSYWAIT, 0);
        @(posedge CLK);
        #1;
        check("illegal_stays_idle", BUSYWAIT, 0);
        READ  = 1'b0;
        WRITE = 1'b0;
        access(1'b0, 8'h05, 8'h00);

        // Randomized traffic over a small address window to exercise read-after-write.
        for (int i = 0; i < 40; i++) begin
            bit         wr;
            logic [7:0] a;
            logic [7:0] d;
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 15));
            d  = 8'($urandom);
            access(wr, a, d);
        end

        // READ held across DONE, then a new read of the top address.
        access(1'b1, 8'hFF, 8'hC3);
        start(1'b0, 8'h3C, 8'h00);
        wait_done();
        check("done_no_retrigger", BUSYWAIT, 0);
        ADDRESS = 8'hFF;
        @(posedge CLK);
        #1;
        issue(1'b0, 8'hFF, 8'h00);
        #1;
        check("idle_retrigger_busy", BUSYWAIT, 1);
        wait_done();
        READ = 1'b0;

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
